// File: rtl/str_match_engine.sv
// Keyword matcher: collects received bytes into a string and reports
// the lowest-index keyword that the string equals.
module str_match_engine #(
  parameter int NUM_KEYS = 4,
  parameter int MAX_LEN = 8,
  parameter logic [NUM_KEYS*MAX_LEN*8-1:0] KEYS = '0,
  parameter int GAP_CYCLES = 20834,
  parameter int USE_TERM = 1,
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter bit CASE_FOLD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_valid,
  input  logic [7:0] rx_data,
  output logic busy,
  output logic result_valid,
  output logic result_hit,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] result_id,
  output logic err_ovf,
  output logic err_drop
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RECV, CMP, DONE} state_t;

  state_t state_q, state_d;
  logic [LW-1:0] len_q;
  logic [GW-1:0] gap_q;
  logic [IW-1:0] k_q, id_q;
  logic ovf_q, hit_q, drop_q;
  logic [7:0] data_q [MAX_LEN];

  logic is_term, byte_in, gap_end, done;
  logic key_eq, key_hit, nul_seen;
  logic [LW-1:0] key_len;
  logic [7:0] key_ch;

  function automatic logic [7:0] fold(input logic [7:0] c);
    if (CASE_FOLD && c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
    return c;
  endfunction

  assign is_term = (USE_TERM != 0) && (rx_data == TERM_CHAR);
  assign byte_in = rx_valid && !is_term;
  assign gap_end = gap_q == GW'(GAP_CYCLES - 1);

  // Key length stops at the first NUL; chars past len are don't-care.
  always_comb begin
    key_len = '0;
    key_eq = 1'b1;
    nul_seen = 1'b0;
    key_ch = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      key_ch = KEYS[(int'(k_q) * MAX_LEN + i) * 8 +: 8];
      if (key_ch == 8'h00) nul_seen = 1'b1;
      else if (!nul_seen) key_len = LW'(i + 1);
      if (LW'(i) < len_q && fold(data_q[i]) != fold(key_ch))
        key_eq = 1'b0;
    end
    key_hit = key_eq && !ovf_q && key_len != '0 && key_len == len_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (byte_in) state_d = RECV;
      RECV: begin
        if (rx_valid && is_term) state_d = CMP;
        else if (!rx_valid && gap_end) state_d = CMP;
      end
      CMP: if (k_q == IW'(NUM_KEYS - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      gap_q <= '0;
      k_q <= '0;
      id_q <= '0;
      ovf_q <= 1'b0;
      hit_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      drop_q <= rx_valid && busy;
      unique case (state_q)
        IDLE: begin
          hit_q <= 1'b0;
          id_q <= '0;
          k_q <= '0;
          if (byte_in) begin
            data_q[0] <= rx_data;
            len_q <= LW'(1);
            gap_q <= '0;
          end
        end
        RECV: begin
          if (byte_in) begin
            if (len_q < LW'(MAX_LEN)) data_q[len_q[AW-1:0]] <= rx_data;
            else ovf_q <= 1'b1;
            if (len_q <= LW'(MAX_LEN)) len_q <= len_q + 1'b1;
            gap_q <= '0;
          end else if (!rx_valid) begin
            gap_q <= gap_q + 1'b1;
          end
        end
        CMP: begin
          if (key_hit && !hit_q) begin
            hit_q <= 1'b1;
            id_q <= k_q;
          end
          k_q <= k_q + 1'b1;
        end
        DONE: begin
          len_q <= '0;
          ovf_q <= 1'b0;
          for (int i = 0; i < MAX_LEN; i++) data_q[i] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign done = state_q == DONE;
  assign busy = (state_q == CMP) || done;
  assign result_valid = done;
  assign result_hit = done && hit_q;
  assign result_id = done ? id_q : '0;
  assign err_ovf = done && ovf_q;
  assign err_drop = drop_q;

endmodule

// File: tb/tb_str_match_engine.sv
// Directed bench for str_match_engine: keyword hits, misses, timing,
// overflow, drop and reset abort, with and without case folding.
module tb_str_match_engine;

  localparam logic [255:0] KEYS = {
    {32'h0, "POTS"}, {24'h0, "zstih"}, {32'h0, "pots"}, {24'h0, "trats"}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic busy, rv, hit, ovf, drop;
  logic [1:0] id;
  logic f_busy, f_rv, f_hit, f_ovf, f_drop;
  logic [1:0] f_id;

  int cyc = 0;
  int n_res = 0, r_cyc = 0, r_hit = 0, r_id = 0, r_ovf = 0;
  int n_drop = 0, d_cyc = 0;
  int f_res = 0, fr_hit = 0, fr_id = 0;
  int n_chk = 0, n_fail = 0;

  str_match_engine #(
    .NUM_KEYS(4), .MAX_LEN(8), .KEYS(KEYS), .GAP_CYCLES(50),
    .USE_TERM(1), .TERM_CHAR(8'h0D), .CASE_FOLD(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .result_valid(rv), .result_hit(hit),
    .result_id(id), .err_ovf(ovf), .err_drop(drop)
  );

  str_match_engine #(
    .NUM_KEYS(4), .MAX_LEN(8), .KEYS(KEYS), .GAP_CYCLES(50),
    .USE_TERM(1), .TERM_CHAR(8'h0D), .CASE_FOLD(1'b1)
  ) u_fold (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(f_busy), .result_valid(f_rv), .result_hit(f_hit),
    .result_id(f_id), .err_ovf(f_ovf), .err_drop(f_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rv) begin
      n_res++;
      r_cyc = cyc;
      r_hit = int'(hit);
      r_id = int'(id);
      r_ovf = int'(ovf);
    end
    if (drop) begin
      n_drop++;
      d_cyc = cyc;
    end
    if (f_rv) begin
      f_res++;
      fr_hit = int'(f_hit);
      fr_id = int'(f_id);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    rx_valid = 1'b1;
    rx_data = b;
    t = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit term, output int t);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], t);
      if (i != s.len() - 1 || term) idle(19);
    end
    if (term) send_byte(8'h0D, t);
  endtask

  task automatic wait_res(input int n0);
    for (int i = 0; i < 150 && n_res == n0; i++) idle(1);
    idle(3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(4);
    n_chk++;
    if ({busy, rv, hit, id, ovf, drop} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 000000",
               {busy, rv, hit, id, ovf, drop});
    end
    n_chk++;
    if ({f_busy, f_rv, f_hit, f_id, f_ovf, f_drop} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_fold_out: got %b want 000000",
               {f_busy, f_rv, f_hit, f_id, f_ovf, f_drop});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_gap;
    int t, n0, f0;
    n0 = n_res;
    f0 = f_res;
    send_str("start", 1'b0, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 1 || r_id !== 0 || r_ovf !== 0) begin
      n_fail++;
      $display("FAIL gap_start: n=%0d hit=%0d id=%0d ovf=%0d want n=%0d 1 0 0",
               n_res - n0, r_hit, r_id, r_ovf, 1);
    end
    n_chk++;
    if (r_cyc !== t + 55) begin
      n_fail++;
      $display("FAIL gap_latency: got cyc %0d want %0d", r_cyc, t + 55);
    end
    n_chk++;
    if (f_res !== f0 + 1 || fr_hit !== 1 || fr_id !== 0) begin
      n_fail++;
      $display("FAIL gap_fold: n=%0d hit=%0d id=%0d want 1 1 0",
               f_res - f0, fr_hit, fr_id);
    end
    idle(10);
  endtask

  task automatic test_term;
    int t, n0;
    n0 = n_res;
    send_str("stop", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 1 || r_id !== 1 || r_cyc !== t + 5) begin
      n_fail++;
      $display("FAIL term_stop: n=%0d hit=%0d id=%0d cyc=%0d want 1 1 1 %0d",
               n_res - n0, r_hit, r_id, r_cyc, t + 5);
    end
    n_chk++;
    if (fr_hit !== 1 || fr_id !== 1) begin
      n_fail++;
      $display("FAIL term_stop_fold: hit=%0d id=%0d want 1 1", fr_hit, fr_id);
    end
    idle(10);
  endtask

  task automatic test_fold;
    int t, n0;
    n0 = n_res;
    send_str("STOP", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (r_hit !== 1 || r_id !== 3) begin
      n_fail++;
      $display("FAIL upper_nofold: hit=%0d id=%0d want 1 3", r_hit, r_id);
    end
    n_chk++;
    if (fr_hit !== 1 || fr_id !== 1) begin
      n_fail++;
      $display("FAIL upper_fold: hit=%0d id=%0d want 1 1", fr_hit, fr_id);
    end
    idle(10);
  endtask

  task automatic test_miss;
    int t, n0;
    n0 = n_res;
    send_str("abc", 1'b0, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 0 || r_id !== 0 || r_ovf !== 0) begin
      n_fail++;
      $display("FAIL miss_abc: n=%0d hit=%0d id=%0d ovf=%0d want 1 0 0 0",
               n_res - n0, r_hit, r_id, r_ovf);
    end
    idle(10);
    n0 = n_res;
    send_str("stops", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 0) begin
      n_fail++;
      $display("FAIL miss_stops: n=%0d hit=%0d want 1 0", n_res - n0, r_hit);
    end
    idle(10);
    n0 = n_res;
    send_str("sta", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 0) begin
      n_fail++;
      $display("FAIL miss_sta: n=%0d hit=%0d want 1 0", n_res - n0, r_hit);
    end
    idle(10);
  endtask

  task automatic test_ovf;
    int t, n0;
    n0 = n_res;
    send_str("hitszhitsz", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 0 || r_ovf !== 1) begin
      n_fail++;
      $display("FAIL ovf_long: n=%0d hit=%0d ovf=%0d want 1 0 1",
               n_res - n0, r_hit, r_ovf);
    end
    idle(10);
    n0 = n_res;
    send_str("hitsz", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 1 || r_id !== 2 || r_ovf !== 0) begin
      n_fail++;
      $display("FAIL ovf_after: n=%0d hit=%0d id=%0d ovf=%0d want 1 1 2 0",
               n_res - n0, r_hit, r_id, r_ovf);
    end
    idle(10);
  endtask

  task automatic test_drop;
    int t, t2, n0, d0;
    n0 = n_res;
    d0 = n_drop;
    send_str("stop", 1'b1, t);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_cmp: got %0d want 1", busy);
    end
    send_byte("x", t2);
    wait_res(n0);
    n_chk++;
    if (n_drop !== d0 + 1 || d_cyc !== t + 2) begin
      n_fail++;
      $display("FAIL drop_pulse: n=%0d cyc=%0d want 1 %0d",
               n_drop - d0, d_cyc, t + 2);
    end
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 1 || r_id !== 1) begin
      n_fail++;
      $display("FAIL drop_result: n=%0d hit=%0d id=%0d want 1 1 1",
               n_res - n0, r_hit, r_id);
    end
    n0 = n_res;
    idle(100);
    send_byte(8'h0D, t);
    idle(100);
    n_chk++;
    if (n_res !== n0) begin
      n_fail++;
      $display("FAIL no_spurious: got %0d results want 0", n_res - n0);
    end
  endtask

  task automatic test_back_to_back;
    int t, n0, d0;
    n0 = n_res;
    d0 = n_drop;
    send_str("stop", 1'b1, t);
    idle(5);
    send_str("start", 1'b1, t);
    wait_res(n0 + 1);
    n_chk++;
    if (n_res !== n0 + 2 || r_hit !== 1 || r_id !== 0 || n_drop !== d0) begin
      n_fail++;
      $display("FAIL b2b_start: n=%0d hit=%0d id=%0d drops=%0d want 2 1 0 0",
               n_res - n0, r_hit, r_id, n_drop - d0);
    end
    idle(10);
  endtask

  task automatic test_rst_abort;
    int t, n0;
    n0 = n_res;
    send_str("hit", 1'b0, t);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_chk++;
    if ({busy, rv, hit, id, ovf, drop} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_recv_out: got %b want 000000",
               {busy, rv, hit, id, ovf, drop});
    end
    idle(100);
    n_chk++;
    if (n_res !== n0) begin
      n_fail++;
      $display("FAIL rst_recv_res: got %0d results want 0", n_res - n0);
    end
    send_str("stop", 1'b1, t);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_chk++;
    if ({busy, rv, hit, id, ovf, drop} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_cmp_out: got %b want 000000",
               {busy, rv, hit, id, ovf, drop});
    end
    idle(30);
    n_chk++;
    if (n_res !== n0) begin
      n_fail++;
      $display("FAIL rst_cmp_res: got %0d results want 0", n_res - n0);
    end
    send_str("start", 1'b1, t);
    wait_res(n0);
    n_chk++;
    if (n_res !== n0 + 1 || r_hit !== 1 || r_id !== 0) begin
      n_fail++;
      $display("FAIL rst_then_start: n=%0d hit=%0d id=%0d want 1 1 0",
               n_res - n0, r_hit, r_id);
    end
  endtask

  initial begin
    idle(1);
    test_reset();
    test_gap();
    test_term();
    test_fold();
    test_miss();
    test_ovf();
    test_drop();
    test_back_to_back();
    test_rst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
